// File: rtl/noc_word_packetizer.sv
// Turns queued 32-bit store words into header + byte-serial payload flits for a router local port.
// Words wait in a small FIFO; flit_out is registered and holds while the router withholds flit_ready.
module noc_word_packetizer #(
  parameter int WORD_W = 32,
  parameter int BYTES  = WORD_W / 8,
  parameter int ID_W   = 4,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   tile_id,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ID_W-1:0]   wr_dest,
  output logic              full,
  output logic              busy,
  output logic              overflow,
  output logic [12:0]       flit_out,
  input  logic              flit_ready,
  output logic [15:0]       pkt_count
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int EW = ID_W + WORD_W;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;

  logic [EW-1:0]     mem_q [QDEPTH];
  logic [AW-1:0]     wrPtr_q, rdPtr_q;
  logic [AW:0]       count_q;
  logic              overflow_q;

  state_e            state_q, state_d;
  logic [12:0]       flit_q, flit_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [ID_W-1:0]   dest_q, dest_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       pktCount_q, pktCount_d;

  logic              push, pop, empty, xfer;
  logic [EW-1:0]     rdEntry;
  logic [ID_W-1:0]   headDest;
  logic [WORD_W-1:0] headData;
  logic [12:0]       headerFlit;
  logic [12:0]       payloadFlit;

  assign full        = (count_q == (AW+1)'(QDEPTH));
  assign empty       = (count_q == '0);
  assign push        = wr_en & ~full;
  assign rdEntry     = mem_q[rdPtr_q];
  assign headDest    = rdEntry[EW-1 -: ID_W];
  assign headData    = rdEntry[WORD_W-1:0];
  assign headerFlit  = {1'b1, 4'(headDest), 4'(tile_id), 4'(BYTES)};
  assign payloadFlit = {1'b1, 4'(dest_q), shift_q[WORD_W-1 -: 8]};
  assign xfer        = flit_q[12] & flit_ready;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {wr_dest, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flit_q     <= '0;
      shift_q    <= '0;
      dest_q     <= '0;
      cnt_q      <= '0;
      pktCount_q <= '0;
    end else begin
      state_q    <= state_d;
      flit_q     <= flit_d;
      shift_q    <= shift_d;
      dest_q     <= dest_d;
      cnt_q      <= cnt_d;
      pktCount_q <= pktCount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    flit_d     = flit_q;
    shift_d    = shift_q;
    dest_d     = dest_q;
    cnt_d      = cnt_q;
    pktCount_d = pktCount_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        flit_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = headData;
          dest_d  = headDest;
          flit_d  = headerFlit;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (xfer) begin
          flit_d  = payloadFlit;
          shift_d = shift_q << 8;
          cnt_d   = '0;
          state_d = BODY;
        end
      end
      BODY: begin
        if (xfer) begin
          if (cnt_q != CW'(BYTES - 1)) begin
            flit_d  = payloadFlit;
            shift_d = shift_q << 8;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            pktCount_d = pktCount_q + 16'd1;
            // Chain straight into the next header so a busy queue leaves no bubble.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = headData;
              dest_d  = headDest;
              flit_d  = headerFlit;
              state_d = HEAD;
            end else begin
              flit_d  = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        flit_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign flit_out  = flit_q;
  assign busy      = ~empty | (state_q != IDLE);
  assign overflow  = overflow_q;
  assign pkt_count = pktCount_q;

endmodule

// File: tb/tb_noc_word_packetizer.sv
// Bench for noc_word_packetizer: a flit-list reference model predicts every output cycle by cycle.
module tb_noc_word_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tile_id = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_dest = '0;
  logic        flit_ready = 1'b1;
  logic        full, busy, overflow;
  logic [12:0] flit_out;
  logic [15:0] pkt_count;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: queued words, the remaining flits of the packet on the wire, counters.
  logic [35:0] mq[$];
  logic [12:0] mcur[$];
  logic [15:0] mPkt = '0;
  logic        mOvf = 1'b0;

  noc_word_packetizer dut (
    .clk(clk), .rst(rst), .tile_id(tile_id), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dest(wr_dest), .full(full), .busy(busy), .overflow(overflow),
    .flit_out(flit_out), .flit_ready(flit_ready), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] expFlit();
    return (mcur.size() != 0) ? mcur[0] : 13'h0;
  endfunction

  function automatic void buildFlits(input logic [35:0] e, input logic [3:0] tid);
    logic [3:0]  d;
    logic [31:0] w;
    d = e[35:32];
    w = e[31:0];
    mcur.push_back({1'b1, d, tid, 4'd4});
    for (int k = 0; k < 4; k++) mcur.push_back({1'b1, d, 8'(w >> (8 * (3 - k)))});
  endfunction

  function automatic void modelStep();
    bit wasFull, wasEmpty;
    logic [35:0] e;
    if (rst) begin
      mq.delete();
      mcur.delete();
      mPkt = '0;
      mOvf = 1'b0;
      return;
    end
    wasFull  = (mq.size() == 4);
    wasEmpty = (mq.size() == 0);
    if (mcur.size() == 0) begin
      if (!wasEmpty) begin
        e = mq.pop_front();
        buildFlits(e, tile_id);
      end
    end else if (flit_ready) begin
      void'(mcur.pop_front());
      if (mcur.size() == 0) begin
        mPkt = mPkt + 16'd1;
        if (!wasEmpty) begin
          e = mq.pop_front();
          buildFlits(e, tile_id);
        end
      end
    end
    if (wr_en) begin
      if (wasFull) mOvf = 1'b1;
      else mq.push_back({wr_dest, wr_data});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nTests++; if (flit_out !== 13'h0) begin nFail++; $display("[TB] FAIL reset_flit: got %h expected 0", flit_out); end
    nTests++; if (full !== 1'b0) begin nFail++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nTests++; if (overflow !== 1'b0) begin nFail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    nTests++; if (pkt_count !== 16'h0) begin nFail++; $display("[TB] FAIL reset_pkt: got %h expected 0", pkt_count); end
  endtask

  task automatic test_single();
    logic [12:0] golden[6];
    golden = '{13'h0, 13'h1524, 13'h15DE, 13'h15AD, 13'h15BE, 13'h15EF};
    tile_id = 4'd2;
    flit_ready = 1'b1;
    wr_dest = 4'd5;
    wr_data = 32'hDEADBEEF;
    for (int c = 0; c < 7; c++) begin
      wr_en = (c == 0);
      tick();
      if (c < 6) begin
        nTests++; if (flit_out !== golden[c]) begin nFail++; $display("[TB] FAIL single_flit%0d: got %h expected %h", c, flit_out, golden[c]); end
      end
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL single_model%0d: got %h expected %h", c, flit_out, expFlit()); end
    end
    wr_en = 1'b0;
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL single_busy: got %b expected 0", busy); end
    nTests++; if (pkt_count !== 16'd1) begin nFail++; $display("[TB] FAIL single_pkt: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_back_to_back();
    int firstV, lastV, nV;
    logic [15:0] pkt0;
    firstV = -1; lastV = -1; nV = 0;
    pkt0 = mPkt;
    tile_id = 4'($urandom);
    flit_ready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      wr_en = (c < 4);
      wr_data = $urandom;
      wr_dest = 4'($urandom);
      tick();
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL b2b_flit%0d: got %h expected %h", c, flit_out, expFlit()); end
      nTests++; if (full !== (mq.size() == 4)) begin nFail++; $display("[TB] FAIL b2b_full%0d: got %b expected %b", c, full, mq.size() == 4); end
      if (flit_out[12]) begin
        if (firstV < 0) firstV = c;
        lastV = c;
        nV++;
      end
    end
    wr_en = 1'b0;
    nTests++; if (nV != 20) begin nFail++; $display("[TB] FAIL b2b_count: got %0d expected 20", nV); end
    nTests++; if (lastV - firstV + 1 != 20) begin nFail++; $display("[TB] FAIL b2b_span: got %0d expected 20", lastV - firstV + 1); end
    nTests++; if (firstV != 1) begin nFail++; $display("[TB] FAIL b2b_latency: got %0d expected 1", firstV); end
    nTests++; if (pkt_count !== pkt0 + 16'd4) begin nFail++; $display("[TB] FAIL b2b_pkt: got %0d expected %0d", pkt_count, pkt0 + 16'd4); end
  endtask

  task automatic test_overflow();
    logic [15:0] pkt0;
    int guard;
    pkt0 = mPkt;
    tile_id = 4'($urandom);
    flit_ready = 1'b0;
    // One word drains into the flit register, four fill the queue, the sixth is dropped.
    for (int c = 0; c < 6; c++) begin
      wr_en = 1'b1;
      wr_data = $urandom;
      wr_dest = 4'($urandom);
      tick();
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL ovf_flit%0d: got %h expected %h", c, flit_out, expFlit()); end
      nTests++; if (overflow !== mOvf) begin nFail++; $display("[TB] FAIL ovf_sticky%0d: got %b expected %b", c, overflow, mOvf); end
    end
    wr_en = 1'b0;
    nTests++; if (overflow !== 1'b1) begin nFail++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
    nTests++; if (full !== 1'b1) begin nFail++; $display("[TB] FAIL ovf_full: got %b expected 1", full); end
    flit_ready = 1'b1;
    guard = 0;
    while ((mq.size() != 0 || mcur.size() != 0) && guard < 60) begin
      tick();
      guard++;
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL ovf_drain%0d: got %h expected %h", guard, flit_out, expFlit()); end
    end
    nTests++; if (pkt_count !== pkt0 + 16'd5) begin nFail++; $display("[TB] FAIL ovf_pkt: got %0d expected %0d", pkt_count, pkt0 + 16'd5); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL ovf_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [12:0] golden[10];
    bit          rdy[10];
    int          guard;
    golden = '{13'h0, 13'h1524, 13'h15DE, 13'h15AD, 13'h15AD, 13'h15AD, 13'h15AD, 13'h15BE, 13'h15EF, 13'h0};
    rdy    = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    tile_id = 4'd2;
    wr_dest = 4'd5;
    wr_data = 32'hDEADBEEF;
    for (int c = 0; c < 10; c++) begin
      wr_en = (c == 0);
      flit_ready = rdy[c];
      tick();
      nTests++; if (flit_out !== golden[c]) begin nFail++; $display("[TB] FAIL bp_flit%0d: got %h expected %h", c, flit_out, golden[c]); end
    end
    // Random stall pattern over several queued words.
    tile_id = 4'($urandom);
    for (int c = 0; c < 60; c++) begin
      wr_en = (c < 3);
      wr_data = $urandom;
      wr_dest = 4'($urandom);
      flit_ready = $urandom_range(0, 1) == 1;
      tick();
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL bp_rand%0d: got %h expected %h", c, flit_out, expFlit()); end
      nTests++; if (pkt_count !== mPkt) begin nFail++; $display("[TB] FAIL bp_pkt%0d: got %0d expected %0d", c, pkt_count, mPkt); end
    end
    wr_en = 1'b0;
    flit_ready = 1'b1;
    guard = 0;
    while ((mq.size() != 0 || mcur.size() != 0) && guard < 40) begin
      tick();
      guard++;
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL bp_drain%0d: got %h expected %h", guard, flit_out, expFlit()); end
    end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL bp_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tile_id = 4'd2;
    flit_ready = 1'b1;
    wr_dest = 4'd5;
    // Second word sits in the queue and must be discarded by the reset.
    for (int c = 0; c < 5; c++) begin
      wr_en = (c < 2);
      wr_data = (c == 0) ? 32'hDEADBEEF : 32'h01234567;
      tick();
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL rmid_flit%0d: got %h expected %h", c, flit_out, expFlit()); end
    end
    wr_en = 1'b0;
    nTests++; if (flit_out !== 13'h15BE) begin nFail++; $display("[TB] FAIL rmid_byte2: got %h expected 15be", flit_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nTests++; if (flit_out !== 13'h0) begin nFail++; $display("[TB] FAIL rmid_flit: got %h expected 0", flit_out); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
    nTests++; if (pkt_count !== 16'h0) begin nFail++; $display("[TB] FAIL rmid_pkt: got %0d expected 0", pkt_count); end
    for (int c = 0; c < 8; c++) begin
      wr_en = (c == 0);
      wr_data = $urandom;
      wr_dest = 4'($urandom);
      tick();
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL rmid_after%0d: got %h expected %h", c, flit_out, expFlit()); end
    end
    wr_en = 1'b0;
    nTests++; if (pkt_count !== 16'd1) begin nFail++; $display("[TB] FAIL rmid_newpkt: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_wrap();
    force dut.pktCount_q = 16'hFFFF;
    tick();
    release dut.pktCount_q;
    mPkt = 16'hFFFF;
    flit_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      wr_en = (c == 0);
      wr_data = $urandom;
      wr_dest = 4'($urandom);
      tick();
      nTests++; if (flit_out !== expFlit()) begin nFail++; $display("[TB] FAIL wrap_flit%0d: got %h expected %h", c, flit_out, expFlit()); end
    end
    wr_en = 1'b0;
    nTests++; if (pkt_count !== 16'h0) begin nFail++; $display("[TB] FAIL wrap_pkt: got %h expected 0", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
